// File: rtl/ddr_addr_gen_mc_if.sv
// Request bus from the multi-channel address generator to the shared DDR address port.
interface ddr_addr_gen_mc_if #(
  parameter int unsigned DDR_ADDR_W = 32,
  parameter int unsigned BURST_W    = 8,
  parameter int unsigned CH_W       = 1
);
  logic [DDR_ADDR_W-1:0] ddr_addr;
  logic [BURST_W-1:0]    ddr_size;
  logic [CH_W-1:0]       ddr_ch;
  logic                  ddr_addr_valid;
  logic                  ddr_addr_ready;

  modport master (
    output ddr_addr, ddr_size, ddr_ch, ddr_addr_valid,
    input  ddr_addr_ready
  );
  modport slave (
    input  ddr_addr, ddr_size, ddr_ch, ddr_addr_valid,
    output ddr_addr_ready
  );
endinterface

// File: rtl/ddr_addr_gen_mc.sv
// Multi-channel strided DDR address generator: per-channel burst sequencing with
// boundary splitting, round-robin arbitration onto one registered request port.
module ddr_addr_gen_mc #(
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned DDR_ADDR_W  = 32,
  parameter int unsigned BURST_W     = 8,
  parameter int unsigned NUM_W       = 16,
  parameter int unsigned BEAT_BYTES  = 64,
  parameter int unsigned BOUND_BYTES = 4096,
  parameter int unsigned CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_NUM-1:0]            start,
  output logic [CH_NUM-1:0]            busy,
  output logic [CH_NUM-1:0]            done,
  input  logic [CH_NUM*DDR_ADDR_W-1:0] st_addr,
  input  logic [CH_NUM*BURST_W-1:0]    burst,
  input  logic [CH_NUM*DDR_ADDR_W-1:0] step,
  input  logic [CH_NUM*NUM_W-1:0]      burst_num,
  ddr_addr_gen_mc_if.master            ddr
);
  localparam int unsigned BeatShift  = $clog2(BEAT_BYTES);
  localparam int unsigned BoundShift = $clog2(BOUND_BYTES);

  typedef logic [DDR_ADDR_W-1:0] addr_t;
  typedef logic [BURST_W-1:0]    beat_t;
  typedef logic [NUM_W-1:0]      num_t;
  typedef logic [CH_W-1:0]       ch_t;
  typedef enum logic {StIdle, StRun} ch_state_e;

  ch_state_e state_q [CH_NUM];
  ch_state_e state_d [CH_NUM];
  addr_t     cur_q [CH_NUM], cur_d [CH_NUM];
  addr_t     base_q [CH_NUM], base_d [CH_NUM];
  addr_t     step_q [CH_NUM], step_d [CH_NUM];
  beat_t     burst_len_q [CH_NUM], burst_len_d [CH_NUM];
  beat_t     beats_left_q [CH_NUM], beats_left_d [CH_NUM];
  num_t      bursts_left_q [CH_NUM], bursts_left_d [CH_NUM];
  logic [CH_NUM-1:0] done_q, done_d;

  addr_t out_addr_q, out_addr_d;
  beat_t out_size_q, out_size_d;
  ch_t   out_ch_q, out_ch_d;
  logic  out_valid_q, out_valid_d;
  ch_t   ptr_q, ptr_d;

  addr_t             room [CH_NUM];
  beat_t             chunk_size [CH_NUM];
  ch_t               rr_idx [CH_NUM];
  logic [CH_NUM-1:0] pending;
  logic              grant_found;
  ch_t               grant_idx;
  logic              load, hs;

  // Chunk = rest of the burst, clipped at the next boundary.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      room[c] = (addr_t'(BOUND_BYTES) - addr_t'(cur_q[c][BoundShift-1:0])) >> BeatShift;
      chunk_size[c] = (addr_t'(beats_left_q[c]) <= room[c]) ? beats_left_q[c]
                                                             : room[c][BURST_W-1:0];
      pending[c] = (state_q[c] == StRun) && (bursts_left_q[c] != '0);
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      rr_idx[i] = ch_t'((int'(ptr_q) + i) % CH_NUM);
      if (!grant_found && pending[rr_idx[i]]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx[i];
      end
    end
  end

  // Channel state advances when its chunk is loaded into the output register; only one chunk
  // per channel can be outstanding, so completion is detected on the handshake of the last one.
  always_comb begin
    load        = !out_valid_q || ddr.ddr_addr_ready;
    hs          = out_valid_q && ddr.ddr_addr_ready;
    out_addr_d  = out_addr_q;
    out_size_d  = out_size_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_addr_d = cur_q[grant_idx];
        out_size_d = chunk_size[grant_idx];
        out_ch_d   = grant_idx;
        ptr_d      = (grant_idx == ch_t'(CH_NUM - 1)) ? '0 : grant_idx + ch_t'(1);
      end
    end

    for (int c = 0; c < CH_NUM; c++) begin
      state_d[c]       = state_q[c];
      cur_d[c]         = cur_q[c];
      base_d[c]        = base_q[c];
      step_d[c]        = step_q[c];
      burst_len_d[c]   = burst_len_q[c];
      beats_left_d[c]  = beats_left_q[c];
      bursts_left_d[c] = bursts_left_q[c];
      done_d[c]        = 1'b0;
      case (state_q[c])
        StIdle: begin
          if (start[c]) begin
            cur_d[c]         = st_addr[c*DDR_ADDR_W +: DDR_ADDR_W];
            base_d[c]        = st_addr[c*DDR_ADDR_W +: DDR_ADDR_W];
            step_d[c]        = step[c*DDR_ADDR_W +: DDR_ADDR_W];
            burst_len_d[c]   = burst[c*BURST_W +: BURST_W];
            beats_left_d[c]  = burst[c*BURST_W +: BURST_W];
            bursts_left_d[c] = burst_num[c*NUM_W +: NUM_W];
            if (burst_num[c*NUM_W +: NUM_W] == '0) begin
              done_d[c] = 1'b1;
            end else begin
              state_d[c] = StRun;
            end
          end
        end
        StRun: begin
          if (load && grant_found && (grant_idx == ch_t'(c))) begin
            if (chunk_size[c] == beats_left_q[c]) begin
              bursts_left_d[c] = bursts_left_q[c] - num_t'(1);
              base_d[c]        = base_q[c] + step_q[c];
              cur_d[c]         = base_q[c] + step_q[c];
              beats_left_d[c]  = burst_len_q[c];
            end else begin
              cur_d[c]        = cur_q[c] + (addr_t'(chunk_size[c]) << BeatShift);
              beats_left_d[c] = beats_left_q[c] - chunk_size[c];
            end
          end
          if (hs && (out_ch_q == ch_t'(c)) && (bursts_left_q[c] == '0)) begin
            state_d[c] = StIdle;
            done_d[c]  = 1'b1;
          end
        end
        default: state_d[c] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        state_q[c]       <= StIdle;
        cur_q[c]         <= '0;
        base_q[c]        <= '0;
        step_q[c]        <= '0;
        burst_len_q[c]   <= '0;
        beats_left_q[c]  <= '0;
        bursts_left_q[c] <= '0;
      end
      done_q      <= '0;
      out_addr_q  <= '0;
      out_size_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        state_q[c]       <= state_d[c];
        cur_q[c]         <= cur_d[c];
        base_q[c]        <= base_d[c];
        step_q[c]        <= step_d[c];
        burst_len_q[c]   <= burst_len_d[c];
        beats_left_q[c]  <= beats_left_d[c];
        bursts_left_q[c] <= bursts_left_d[c];
      end
      done_q      <= done_d;
      out_addr_q  <= out_addr_d;
      out_size_q  <= out_size_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      busy[c] = (state_q[c] == StRun);
    end
  end

  assign done               = done_q;
  assign ddr.ddr_addr       = out_addr_q;
  assign ddr.ddr_size       = out_size_q;
  assign ddr.ddr_ch         = out_ch_q;
  assign ddr.ddr_addr_valid = out_valid_q;
endmodule

// File: tb/tb_ddr_addr_gen_mc.sv
// Scoreboard bench for ddr_addr_gen_mc: a chunk-list reference model fills per-channel
// queues; a negedge monitor checks every handshake, busy/done timing and bus stability.
module tb_ddr_addr_gen_mc;
  localparam int unsigned AW = 32, BW = 8, NW = 16, BEAT = 64, BOUND = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = '0;
  logic [1:0]  busy, done;
  logic [63:0] st_addr = '0, step = '0;
  logic [15:0] burst = '0;
  logic [31:0] burst_num = '0;

  ddr_addr_gen_mc_if #(.DDR_ADDR_W(AW), .BURST_W(BW), .CH_W(1)) ddr ();

  ddr_addr_gen_mc #(
    .CH_NUM(2), .DDR_ADDR_W(AW), .BURST_W(BW), .NUM_W(NW),
    .BEAT_BYTES(BEAT), .BOUND_BYTES(BOUND)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .st_addr(st_addr), .burst(burst), .step(step), .burst_num(burst_num), .ddr(ddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [7:0] size;} chunk_t;

  int     cyc = 0;
  int     n_tests = 0, n_fail = 0;
  chunk_t exp_q [2][$];
  int     done_exp [2][$];
  int     ord_q [$];
  bit     active [2];
  int     start_cyc [2];
  bit     prev_v, prev_r;
  logic [40:0] prev_bus;
  int     mon_ch;
  chunk_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = '0;
  endtask

  task automatic clear_model();
    for (int c = 0; c < 2; c++) begin
      exp_q[c].delete();
      done_exp[c].delete();
      active[c] = 1'b0;
    end
    ord_q.delete();
  endtask

  // Reference model: expand a program into its list of boundary-clipped chunks.
  task automatic set_ch(input int c, input logic [31:0] a, input logic [7:0] b,
                        input logic [31:0] s, input logic [15:0] n);
    logic [31:0] base, cur;
    int left, room, sz;
    chunk_t e;
    st_addr[c*32 +: 32]   = a;
    step[c*32 +: 32]      = s;
    burst[c*8 +: 8]       = b;
    burst_num[c*16 +: 16] = n;
    start[c]              = 1'b1;
    if (!active[c]) begin
      if (n == 0) begin
        done_exp[c].push_back(cyc + 1);
      end else begin
        active[c]    = 1'b1;
        start_cyc[c] = cyc;
        base = a;
        for (int k = 0; k < int'(n); k++) begin
          cur  = base;
          left = int'(b);
          while (left > 0) begin
            room = int'((BOUND - (cur % BOUND)) / BEAT);
            sz   = (left < room) ? left : room;
            e.addr = cur;
            e.size = 8'(sz);
            exp_q[c].push_back(e);
            cur  = cur + 32'(sz * BEAT);
            left = left - sz;
          end
          base = base + s;
        end
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < bound; i++) begin
      idle = !active[0] && !active[1] && done_exp[0].size() == 0 && done_exp[1].size() == 0;
      if (idle) break;
      tick();
    end
    check("wait_idle_timeout", 64'(idle), 64'd1);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    start = '0;
    clear_model();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          check($sformatf("busy%0d", c), 64'(busy[c]), 64'(active[c] && cyc > start_cyc[c]));
          if (done_exp[c].size() > 0 && done_exp[c][0] == cyc) begin
            check($sformatf("done%0d", c), 64'(done[c]), 64'd1);
            void'(done_exp[c].pop_front());
          end else begin
            check($sformatf("done%0d", c), 64'(done[c]), 64'd0);
          end
        end
        if (prev_v && !prev_r) begin
          check("stall_hold", {ddr.ddr_addr_valid, ddr.ddr_addr, ddr.ddr_size, ddr.ddr_ch},
                {1'b1, prev_bus});
        end
        if (ddr.ddr_addr_valid && ddr.ddr_addr_ready) begin
          mon_ch = int'(ddr.ddr_ch);
          if (ord_q.size() > 0) check("rr_order", 64'(mon_ch), 64'(ord_q.pop_front()));
          n_tests++;
          if (exp_q[mon_ch].size() == 0) begin
            n_fail++;
            $display("FAIL spurious_req: got ch%0d addr 0x%0h size %0d, expected no request",
                     mon_ch, ddr.ddr_addr, ddr.ddr_size);
          end else begin
            mon_e = exp_q[mon_ch].pop_front();
            check($sformatf("addr_ch%0d", mon_ch), 64'(ddr.ddr_addr), 64'(mon_e.addr));
            check($sformatf("size_ch%0d", mon_ch), 64'(ddr.ddr_size), 64'(mon_e.size));
            if (exp_q[mon_ch].size() == 0) begin
              active[mon_ch] = 1'b0;
              done_exp[mon_ch].push_back(cyc + 1);
            end
          end
        end
        prev_v   = ddr.ddr_addr_valid;
        prev_r   = ddr.ddr_addr_ready;
        prev_bus = {ddr.ddr_addr, ddr.ddr_size, ddr.ddr_ch};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [40:0] held;
    logic [31:0] ra, rs;
    int          rb;
    ddr.ddr_addr_ready = 1'b1;
    clear_model();
    #12;
    check("rst_valid", 64'(ddr.ddr_addr_valid), 64'd0);
    check("rst_bus", {ddr.ddr_addr, ddr.ddr_size, ddr.ddr_ch}, 64'd0);
    check("rst_busy_done", {busy, done}, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Three aligned bursts with start-to-valid latency check and an ignored restart.
    set_ch(0, 32'h1000, 8'd16, 32'h400, 16'd3);
    tick();
    @(negedge clk);
    check("latency_c1_valid", 64'(ddr.ddr_addr_valid), 64'd0);
    tick();
    @(negedge clk);
    check("latency_c2_valid", 64'(ddr.ddr_addr_valid), 64'd1);
    set_ch(0, 32'h9000, 8'd5, 32'h40, 16'd7);
    tick();
    wait_idle(100);

    // Boundary splits: two chunks, then a burst spanning three.
    set_ch(0, 32'h0FC0, 8'd4, 32'h0, 16'd1);
    tick();
    wait_idle(100);
    set_ch(1, 32'h0F80, 8'd130, 32'h40, 16'd2);
    tick();
    wait_idle(100);

    // Both channels together from a fresh pointer.
    do_reset();
    set_ch(0, 32'h2000, 8'd8, 32'h100, 16'd2);
    set_ch(1, 32'h3000, 8'd8, 32'h100, 16'd2);
    ord_q = '{0, 1, 0, 1};
    tick();
    wait_idle(100);

    // Backpressure: request must be held for five stalled cycles.
    ddr.ddr_addr_ready = 1'b0;
    set_ch(0, 32'h4000, 8'd4, 32'h40, 16'd3);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ddr.ddr_addr_valid) break;
      tick();
    end
    held = {ddr.ddr_addr, ddr.ddr_size, ddr.ddr_ch};
    repeat (5) begin
      tick();
      @(negedge clk);
    end
    check("stall_valid", 64'(ddr.ddr_addr_valid), 64'd1);
    check("stall_bus", 64'({ddr.ddr_addr, ddr.ddr_size, ddr.ddr_ch}), 64'(held));
    tick();
    ddr.ddr_addr_ready = 1'b1;
    wait_idle(100);

    // Zero bursts: done only, no request.
    set_ch(1, 32'h5000, 8'd4, 32'h0, 16'd0);
    tick();
    repeat (3) begin
      @(negedge clk);
      check("num0_valid", 64'(ddr.ddr_addr_valid), 64'd0);
      tick();
    end
    wait_idle(20);

    // Asynchronous reset mid-sequence, then a clean run.
    set_ch(0, 32'h6000, 8'd16, 32'h400, 16'd10);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(ddr.ddr_addr_valid), 64'd0);
    check("midrst_busy_done", 64'({busy, done}), 64'd0);
    clear_model();
    tick();
    tick();
    rst = 1'b1;
    set_ch(0, 32'h7000, 8'd2, 32'h80, 16'd2);
    tick();
    wait_idle(100);

    // Randomized programs with random backpressure.
    for (int it = 0; it < 600; it++) begin
      ddr.ddr_addr_ready = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 11) == 0) begin
          ra = $urandom & 32'hFFFF_FFC0;
          rb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 200) : $urandom_range(1, 20);
          rs = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFC0)
                                           : 32'($urandom_range(0, 64) * 64);
          set_ch(c, ra, 8'(rb), rs, 16'($urandom_range(0, 4)));
        end
      end
      tick();
    end
    ddr.ddr_addr_ready = 1'b1;
    wait_idle(5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
